// File: rtl/aes_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : aes_frame_assembler
// Description : Pops 16 FIFO entries (key byte + plaintext byte each),
//               assembles a 128-bit key and plaintext block, runs one AES-128
//               encryption through a start/done handshake and holds the
//               ciphertext for word-wise readback.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_frame_assembler #(
    parameter int          NBYTES   = 16,
    parameter logic [15:0] END_FLAG = 16'h1111
) (
    input  logic         clk_main_a0,
    input  logic         rst_main_sync,
    // host-write FIFO
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    input  logic [31:0]  fifo_rdata,
    // AES core
    output logic [127:0] aes_key,
    output logic [127:0] aes_din,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_dout,
    // result readback
    input  logic         rd_req,
    input  logic [1:0]   rd_idx,
    output logic [31:0]  rd_data,
    output logic         rd_valid,
    // status
    output logic         result_ready,
    output logic         frame_err,
    input  logic         err_clr,
    output logic         busy
);

    // Index of the entry that must carry the end flag.
    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_CAPT   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   key_sr_q, key_sr_d;
    logic [127:0]   din_sr_q, din_sr_d;
    logic [127:0]   ct_q, ct_d;
    logic           result_ready_q, result_ready_d;
    logic           frame_err_q, frame_err_d;
    logic [31:0]    rd_data_q, rd_data_d;
    logic           rd_valid_q;

    logic           pop;
    logic           start;
    logic           err_set;
    logic           is_end;
    logic           is_last;
    logic [31:0]    ct_word;

    assign is_end  = (fifo_rdata[31:16] == END_FLAG);
    assign is_last = (cnt_q == LAST_IDX);

    // State, counter and datapath registers; everything clears on reset.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            state_q        <= ST_FETCH;
            cnt_q          <= 4'd0;
            key_sr_q       <= 128'd0;
            din_sr_q       <= 128'd0;
            ct_q           <= 128'd0;
            result_ready_q <= 1'b0;
            frame_err_q    <= 1'b0;
            rd_data_q      <= 32'd0;
            rd_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            key_sr_q       <= key_sr_d;
            din_sr_q       <= din_sr_d;
            ct_q           <= ct_d;
            result_ready_q <= result_ready_d;
            frame_err_q    <= frame_err_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_req;
        end
    end

    // Frame FSM: next state, shift-in of entry bytes, AES handshake.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        key_sr_d       = key_sr_q;
        din_sr_d       = din_sr_q;
        ct_d           = ct_q;
        result_ready_d = result_ready_q;
        pop            = 1'b0;
        start          = 1'b0;
        err_set        = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                // Bytes always shift in; a discarded frame is simply
                // overwritten by the next 16 entries.
                key_sr_d = {key_sr_q[119:0], fifo_rdata[15:8]};
                din_sr_d = {din_sr_q[119:0], fifo_rdata[7:0]};
                if (is_last && is_end) begin
                    cnt_d   = 4'd0;
                    state_d = ST_START;
                end else if (is_last || is_end) begin
                    // Missing end flag on the last entry, or premature end.
                    err_set = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ST_FETCH;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = ST_FETCH;
                end
            end
            ST_START: begin
                start   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (aes_done) begin
                    ct_d           = aes_dout;
                    result_ready_d = 1'b1;
                    state_d        = ST_RESULT;
                end
            end
            ST_RESULT: begin
                // Reading the last word consumes the result.
                if (rd_req && (rd_idx == 2'd3)) begin
                    result_ready_d = 1'b0;
                    state_d        = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Sticky framing error; a new error beats a simultaneous clear.
    always_comb begin
        frame_err_d = frame_err_q;
        if (err_set) begin
            frame_err_d = 1'b1;
        end else if (err_clr) begin
            frame_err_d = 1'b0;
        end
    end

    // Readback word select; zeros unless a result is held.
    always_comb begin
        ct_word   = 32'd0;
        rd_data_d = rd_data_q;
        case (rd_idx)
            2'd0:    ct_word = ct_q[127:96];
            2'd1:    ct_word = ct_q[95:64];
            2'd2:    ct_word = ct_q[63:32];
            default: ct_word = ct_q[31:0];
        endcase
        if (rd_req) begin
            rd_data_d = result_ready_q ? ct_word : 32'd0;
        end
    end

    assign fifo_rd_en   = pop & ~rst_main_sync;
    assign aes_start    = start & ~rst_main_sync;
    assign aes_key      = key_sr_q;
    assign aes_din      = din_sr_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign result_ready = result_ready_q;
    assign frame_err    = frame_err_q;
    assign busy         = !((state_q == ST_FETCH) && (cnt_q == 4'd0));

endmodule
`default_nettype wire

// File: tb/tb_aes_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_frame_assembler
// Description : Directed self-checking bench for aes_frame_assembler with a
//               small FIFO model and a hand-driven AES core handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_frame_assembler;

    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [31:0]  fifo_rdata = 32'd0;
    logic [127:0] aes_key, aes_din;
    logic         aes_start;
    logic         aes_done = 1'b0;
    logic [127:0] aes_dout = 128'd0;
    logic         rd_req = 1'b0;
    logic [1:0]   rd_idx = 2'd0;
    logic [31:0]  rd_data;
    logic         rd_valid;
    logic         result_ready;
    logic         frame_err;
    logic         err_clr = 1'b0;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;

    // FIFO model: bench writes entries, the read side answers pops.
    logic [31:0] mem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rdata <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 8'd1;
        end
        if (aes_start) start_cnt <= start_cnt + 1;
    end

    aes_frame_assembler #(
        .NBYTES   (16),
        .END_FLAG (16'h1111)
    ) dut (
        .clk_main_a0   (clk),
        .rst_main_sync (rst),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rdata    (fifo_rdata),
        .aes_key       (aes_key),
        .aes_din       (aes_din),
        .aes_start     (aes_start),
        .aes_done      (aes_done),
        .aes_dout      (aes_dout),
        .rd_req        (rd_req),
        .rd_idx        (rd_idx),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .result_ready  (result_ready),
        .frame_err     (frame_err),
        .err_clr       (err_clr),
        .busy          (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entries lo..hi of a frame: key byte i, plaintext byte i*0x11.
    task automatic push_range(input int lo, input int hi, input int end_at,
                              input logic [15:0] filler);
        for (int i = lo; i <= hi; i++) begin
            mem[wr_ptr] = {(i == end_at) ? 16'h1111 : filler, 8'(i), 8'(i * 17)};
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!aes_start && n < 200);
        chk("start_seen", {127'd0, aes_start}, 128'd1);
    endtask

    task automatic pulse_done();
        aes_done = 1'b1;
        aes_dout = C_CT;
        tick();
        aes_done = 1'b0;
        aes_dout = 128'd0;
    endtask

    task automatic read_word(input logic [1:0] idx, input logic [31:0] exp, input string tag);
        rd_req = 1'b1;
        rd_idx = idx;
        tick();
        rd_req = 1'b0;
        chk({tag, "_valid"}, {127'd0, rd_valid}, 128'd1);
        chk(tag, {96'd0, rd_data}, {96'd0, exp});
    endtask

    initial begin
        int n;
        int viol;

        // Reset state
        repeat (3) tick();
        chk("rst_fifo_rd_en",   {127'd0, fifo_rd_en},   128'd0);
        chk("rst_aes_start",    {127'd0, aes_start},    128'd0);
        chk("rst_aes_key",      aes_key,                128'd0);
        chk("rst_aes_din",      aes_din,                128'd0);
        chk("rst_rd_data",      {96'd0, rd_data},       128'd0);
        chk("rst_rd_valid",     {127'd0, rd_valid},     128'd0);
        chk("rst_result_ready", {127'd0, result_ready}, 128'd0);
        chk("rst_frame_err",    {127'd0, frame_err},    128'd0);
        chk("rst_busy",         {127'd0, busy},         128'd0);
        rst = 1'b0;
        tick();

        // Read before any result: zero data, valid pulse, no state effect
        read_word(2'd1, 32'd0, "early_rd1");
        read_word(2'd3, 32'd0, "early_rd3");
        chk("early_rr", {127'd0, result_ready}, 128'd0);
        chk("early_busy", {127'd0, busy}, 128'd0);

        // FIPS-197 vector
        push_range(0, 15, 15, 16'h0000);
        wait_start(n);
        chk("fips_latency", 128'(n), 128'd32);
        chk("fips_key", aes_key, C_KEY);
        chk("fips_din", aes_din, C_PT);
        tick();
        chk("fips_start_low", {127'd0, aes_start}, 128'd0);
        chk("fips_start_cnt", 128'(start_cnt), 128'd1);
        chk("fips_busy_wait", {127'd0, busy}, 128'd1);
        tick();
        pulse_done();
        chk("fips_rr", {127'd0, result_ready}, 128'd1);
        read_word(2'd0, 32'h69c4e0d8, "fips_w0");
        read_word(2'd1, 32'h6a7b0430, "fips_w1");
        read_word(2'd2, 32'hd8cdb780, "fips_w2");
        read_word(2'd3, 32'h70b4c55a, "fips_w3");
        chk("fips_rr_clr", {127'd0, result_ready}, 128'd0);
        read_word(2'd0, 32'd0, "fips_after");

        // Premature end flag on entry 8, then a good frame with noisy flags
        push_range(0, 7, 7, 16'h0000);
        repeat (20) tick();
        chk("pre_err", {127'd0, frame_err}, 128'd1);
        chk("pre_start_cnt", 128'(start_cnt), 128'd1);
        chk("pre_busy", {127'd0, busy}, 128'd0);
        push_range(0, 15, 15, 16'h5a5a);
        wait_start(n);
        chk("pre_latency", 128'(n), 128'd32);
        chk("pre_key", aes_key, C_KEY);
        chk("pre_din", aes_din, C_PT);
        tick();
        pulse_done();
        read_word(2'd3, 32'h70b4c55a, "pre_w3");
        chk("pre_err_held", {127'd0, frame_err}, 128'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("pre_err_clr", {127'd0, frame_err}, 128'd0);

        // Missing end flag on entry 16
        push_range(0, 15, -1, 16'h0000);
        repeat (36) tick();
        chk("miss_err", {127'd0, frame_err}, 128'd1);
        chk("miss_start_cnt", 128'(start_cnt), 128'd2);
        chk("miss_busy", {127'd0, busy}, 128'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("miss_err_clr", {127'd0, frame_err}, 128'd0);

        // Starved FIFO after entry 5
        push_range(0, 4, 15, 16'h0000);
        repeat (12) tick();
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            if (fifo_rd_en !== 1'b0) viol++;
            tick();
        end
        chk("starve_no_pop", 128'(viol), 128'd0);
        chk("starve_busy", {127'd0, busy}, 128'd1);
        push_range(5, 15, 15, 16'h0000);
        wait_start(n);
        chk("starve_key", aes_key, C_KEY);
        chk("starve_din", aes_din, C_PT);
        tick();
        pulse_done();
        read_word(2'd3, 32'h70b4c55a, "starve_w3");
        chk("starve_err", {127'd0, frame_err}, 128'd0);

        // Reset while waiting for the AES core, then a late done
        push_range(0, 15, 15, 16'h0000);
        wait_start(n);
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_aes_key",   aes_key,                128'd0);
        chk("mrst_aes_din",   aes_din,                128'd0);
        chk("mrst_rd_data",   {96'd0, rd_data},       128'd0);
        chk("mrst_start",     {127'd0, aes_start},    128'd0);
        chk("mrst_fifo_rd",   {127'd0, fifo_rd_en},   128'd0);
        chk("mrst_busy",      {127'd0, busy},         128'd0);
        rst = 1'b0;
        pulse_done();
        tick();
        chk("mrst_late_done", {127'd0, result_ready}, 128'd0);
        chk("mrst_start_cnt", 128'(start_cnt), 128'd4);
        read_word(2'd0, 32'd0, "mrst_rd0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_frame_assembler.md
# aes_frame_assembler

Downstream consumer of the host-write FIFO in the AES custom logic. It pops 16 FIFO entries, each carrying one key byte and one plaintext byte MSB-first, and assembles them into a 128-bit key and a 128-bit plaintext block. It then runs one AES-128 encryption through a start/done handshake with the AES core and holds the 128-bit ciphertext for word-wise readback by the AXI-Lite read path.

## Interface
Parameters:
- NBYTES, 16, entries per frame (fixed for AES-128)
- END_FLAG, 16'h1111, value of entry[31:16] marking the last entry of a frame

Ports:
- clk_main_a0  in  1  main clock
- rst_main_sync  in  1  synchronous, active-high reset
- fifo_empty  in  1  FIFO has no entries
- fifo_rd_en  out  1  pop strobe; FIFO presents fifo_rdata the following cycle
- fifo_rdata  in  32  [31:16] flag, [15:8] key byte, [7:0] plaintext byte
- aes_key  out  128  assembled key; first popped byte lands in [127:120]
- aes_din  out  128  assembled plaintext; same byte order as aes_key
- aes_start  out  1  one-cycle start pulse to the AES core
- aes_done  in  1  one-cycle completion pulse from the AES core
- aes_dout  in  128  ciphertext; valid in the aes_done cycle
- rd_req  in  1  read request for one result word
- rd_idx  in  2  word select; 0 = ct[127:96] … 3 = ct[31:0]
- rd_data  out  32  registered read data
- rd_valid  out  1  one-cycle pulse, one cycle after rd_req
- result_ready  out  1  ciphertext held and unread
- frame_err  out  1  sticky framing error
- err_clr  in  1  clears frame_err
- busy  out  1  high in every state except FETCH with byte count 0

## Operation
The FSM has five states: FETCH, CAPT, START, WAIT, RESULT.

- **FETCH:** if !fifo_empty, assert fifo_rd_en for one cycle and go to CAPT; otherwise stay.
- **CAPT:** shift in the new bytes: key_sr <= {key_sr[119:0], fifo_rdata[15:8]} and din_sr <= {din_sr[119:0], fifo_rdata[7:0]}.
  - If cnt==15 and flag==END_FLAG: cnt <= 0, go to START.
  - If cnt==15 and flag!=END_FLAG: set frame_err, cnt <= 0, discard the frame, go to FETCH.
  - If cnt<15 and flag==END_FLAG (premature end): set frame_err, cnt <= 0, discard, go to FETCH.
  - Otherwise: cnt <= cnt+1, go to FETCH.
- **START:** aes_start=1 for exactly one cycle; go to WAIT. aes_key and aes_din are stable from START until the next frame begins shifting.
- **WAIT:** on aes_done, capture aes_dout into ct_reg, set result_ready, go to RESULT. aes_done in any other state is ignored.
- **RESULT:** hold ct_reg. A read with rd_idx==3 consumes the result: result_ready clears on the next cycle and the FSM goes to FETCH. No FIFO pops occur while in START, WAIT or RESULT.
- **Readback:** available in any state. rd_data = ct_reg word rd_idx when result_ready, else 32'h0. rd_valid always pulses in response to rd_req.
- **Flag handling:** any flag value other than END_FLAG on entries 0–14 is accepted and ignored.
- **frame_err:** sticky; cleared only by err_clr or reset. If err_clr and a new error occur in the same cycle, the error wins.

## Timing
- **Reset values** (all outputs and registers 0 on rst_main_sync=1 at a clock edge): fifo_rd_en, aes_start, aes_key, aes_din, rd_data, rd_valid, result_ready, frame_err, busy = 0; cnt=0; ct_reg=0; state=FETCH.
- **Reset mid-frame or mid-encryption:** the partial frame is discarded. A later aes_done is ignored because the FSM is no longer in WAIT.
- **Per-entry cost:** 2 cycles (pop, capture). With the FIFO never empty, 16 entries take 32 cycles.
- **Last entry to start:** aes_start asserts 1 cycle after the CAPT cycle of entry 16.
- **Done to ready:** result_ready rises the cycle after aes_done.
- **Read latency:** 1 cycle from rd_req to rd_data/rd_valid. Back-to-back reads are allowed, one per cycle.
- **Empty FIFO mid-frame:** the FSM waits in FETCH with cnt preserved. No timeout.
- **rd_req with rd_idx==3 while result_ready=0:** returns 0 and has no state effect.

## Test plan
- **FIPS-197 vector.** Push 16 entries with key 000102…0f and plaintext 00112233…ff, entry 16 flag=1111. Expected:
  - aes_key=000102030405060708090a0b0c0d0e0f, aes_din=00112233445566778899aabbccddeeff, one aes_start pulse.
  - After aes_done, reads 0..3 return 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
  - result_ready falls after the read of word 3.
- **Premature flag.** Flag 1111 on entry 8 sets frame_err with no aes_start. A following correct 16-entry frame encrypts normally and frame_err stays 1 until err_clr.
- **Missing flag.** Entry 16 with flag 0000 sets frame_err, no aes_start, cnt returns to 0.
- **Starved FIFO.** fifo_empty held high for 10 cycles after entry 5: fifo_rd_en stays low, and the frame completes correctly once data resumes.
- **Reset mid-run.** Reset asserted in WAIT: all outputs become 0, and a late aes_done does not set result_ready.
- **Read before result.** rd_req with rd_idx=1 while result_ready=0 returns rd_data=0 with rd_valid=1.
